ad_ip_jesd204_tpl_dac_fifo: RTL and testbench

// - Elastic buffer directly upstream of the JESD204 TPL DAC core, in the link_clk domain.
// - Accepts frame-packed DMA words over an AXI-stream-style valid/ready port.
// - Presents each word show-ahead on dac_ddata; pops on the core's dac_valid strobe.
// - Prefills to a start level before releasing data. Flags underflow on dac_dunf.

---
 rtl/ad_ip_jesd204_tpl_pkg.sv | 22 ++
 rtl/ad_ip_jesd204_tpl_dac_fifo_if.sv | 30 +++
 rtl/ad_mem_dp.sv | 40 ++++
 rtl/ad_ip_jesd204_tpl_dac_fifo.sv | 135 +++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad_ip_jesd204_tpl_pkg.sv
`default_nettype none
// ============================================================================
// | Package  : ad_ip_jesd204_tpl_pkg                                         |
// | Brief    : Shared types and helpers for the JESD204 TPL DAC data path    |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
package ad_ip_jesd204_tpl_pkg;

  // FIFO control states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Number of stored words for a given address width.
  function automatic int fifo_depth(input int address_width);
    return 1 << address_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_if.sv
`default_nettype none
// ============================================================================
// | Interface : ad_ip_jesd204_tpl_dac_fifo_if                                |
// | Brief     : AXI-stream style valid/ready/data link into the DAC FIFO     |
// | Revision  : 1.0 - initial release                                        |
// ============================================================================
interface ad_ip_jesd204_tpl_dac_fifo_if #(
  parameter int DATA_WIDTH = 128
);

  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic [DATA_WIDTH-1:0] s_axis_data;

  // Upstream (DMA side) view.
  modport master (
    output s_axis_valid,
    output s_axis_data,
    input  s_axis_ready
  );

  // FIFO view.
  modport slave (
    input  s_axis_valid,
    input  s_axis_data,
    output s_axis_ready
  );

endinterface
`default_nettype wire

// File: rtl/ad_mem_dp.sv
`default_nettype none
// ============================================================================
// | Module   : ad_mem_dp                                                     |
// | Brief    : Simple dual-port RAM, one write port, one read port with a    |
// |            read enable and one cycle of read latency                     |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module ad_mem_dp #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     wr_en,
  input  wire logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  wire logic [DATA_WIDTH-1:0]    wr_data,
  input  wire logic                     rd_en,
  input  wire logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0]    rd_data
);

  localparam int C_WORDS = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:C_WORDS-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Store a word on every write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Registered read; the register only updates when a read is requested so it
  // can serve as the holding register of the consumer.
  always_ff @(posedge clk) begin
    if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
`default_nettype none
// ============================================================================
// | Module   : ad_ip_jesd204_tpl_dac_fifo                                    |
// | Brief    : Prefilling elastic buffer in front of the JESD204 TPL DAC     |
// |            core. Show-ahead output, popped by dac_valid, underflow flag. |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module ad_ip_jesd204_tpl_dac_fifo
  import ad_ip_jesd204_tpl_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDRESS_WIDTH = 4,
  parameter int START_LEVEL   = 8
) (
  input  wire logic                      clk,
  input  wire logic                      resetn,
  input  wire logic [NUM_CHANNELS-1:0]   enable,
  ad_ip_jesd204_tpl_dac_fifo_if.slave    s_axis,
  input  wire logic [NUM_CHANNELS-1:0]   dac_valid,
  output logic      [DATA_WIDTH-1:0]     dac_ddata,
  output logic                           dac_dunf,
  output logic      [ADDRESS_WIDTH:0]    fifo_level
);

  localparam int                   C_DEPTH     = fifo_depth(ADDRESS_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] C_FULL_LVL  = (ADDRESS_WIDTH+1)'(C_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] C_START_LVL = (ADDRESS_WIDTH+1)'(START_LEVEL);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0]   r_level;
  logic                     r_ovalid;
  logic                     r_dunf;

  logic                     w_en;
  logic                     w_rd;
  logic                     w_full;
  logic                     w_ready;
  logic                     w_wr;
  logic                     w_load;
  logic                     w_pop;
  logic                     w_dunf;
  logic [DATA_WIDTH-1:0]    w_mem_rd_data;

  assign w_en   = |enable;
  assign w_rd   = |dac_valid;
  // Full is judged on the registered level only; a read in the same cycle
  // does not reopen the input.
  assign w_full = (r_level == C_FULL_LVL);

  // Next state and per-cycle strobes; a zero enable overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_dunf      = 1'b0;
    if (!w_en) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_state_nxt = FILL;
        FILL: begin
          w_ready = !w_full;
          if (r_level >= C_START_LVL) w_state_nxt = RUN;
        end
        RUN: begin
          w_ready = !w_full;
          w_pop   = w_rd && r_ovalid;
          w_dunf  = w_rd && !r_ovalid;
          // Refill the output register when it is empty or being consumed.
          w_load  = (r_level != '0) && (!r_ovalid || w_rd);
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    w_wr = s_axis.s_axis_valid && w_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Pointers, level counter, output-valid flag and underflow pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovalid <= 1'b0;
      r_dunf   <= 1'b0;
    end else if (!w_en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovalid <= 1'b0;
      r_dunf   <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
      r_level <= r_level + (ADDRESS_WIDTH+1)'(w_wr) - (ADDRESS_WIDTH+1)'(w_load);
      if (w_load)     r_ovalid <= 1'b1;
      else if (w_pop) r_ovalid <= 1'b0;
      r_dunf <= w_dunf;
    end
  end

  // The RAM read register doubles as the output register: it is only
  // written on a load, and ovalid decides whether its contents are shown.
  ad_mem_dp #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr),
    .wr_addr (r_wr_ptr),
    .wr_data (s_axis.s_axis_data),
    .rd_en   (w_load),
    .rd_addr (r_rd_ptr),
    .rd_data (w_mem_rd_data)
  );

  assign s_axis.s_axis_ready = w_ready;
  // Midscale (zero) whenever no valid word is held.
  assign dac_ddata  = r_ovalid ? w_mem_rd_data : '0;
  assign dac_dunf   = r_dunf;
  assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
`default_nettype none
// ============================================================================
// | Module   : tb_ad_ip_jesd204_tpl_dac_fifo                                 |
// | Brief    : Self-checking bench: queue-based reference model compared     |
// |            every cycle, plus directed scenarios with literal values      |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module tb_ad_ip_jesd204_tpl_dac_fifo;

  localparam int DW    = 128;
  localparam int NC    = 2;
  localparam int AW    = 4;
  localparam int START = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NC-1:0] enable;
  logic [NC-1:0] dac_valid;
  logic [DW-1:0] dac_ddata;
  logic          dac_dunf;
  logic [AW:0]   fifo_level;

  ad_ip_jesd204_tpl_dac_fifo_if #(.DATA_WIDTH(DW)) axis_if ();

  ad_ip_jesd204_tpl_dac_fifo #(
    .DATA_WIDTH    (DW),
    .NUM_CHANNELS  (NC),
    .ADDRESS_WIDTH (AW),
    .START_LEVEL   (START)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .s_axis     (axis_if),
    .dac_valid  (dac_valid),
    .dac_ddata  (dac_ddata),
    .dac_dunf   (dac_dunf),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: stored words, one output slot, a mode and the dunf flag.
  logic [DW-1:0] mq[$];
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_dunf;
  int            m_st;      // 0 idle, 1 prefill, 2 running
  bit            m_rdy;
  bit            m_wr;
  bit            m_rd;

  // Observed output stream and underflow statistics.
  logic [DW-1:0] cap[$];
  int            dunf_cnt  = 0;
  int            dunf_rise = 0;
  bit            dunf_prev = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Compare against the model mid-cycle, then advance the model across the
  // coming rising edge using the inputs that will be sampled there.
  always @(negedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_ov = 1'b0; m_od = '0; m_dunf = 1'b0; m_st = 0; dunf_prev = 1'b0;
    end else begin
      m_rdy = (m_st != 0) && (mq.size() < DEPTH) && (enable != '0);
      check("cmp_ready", DW'(axis_if.s_axis_ready), DW'(m_rdy));
      check("cmp_ddata", dac_ddata, m_ov ? m_od : '0);
      check("cmp_dunf",  DW'(dac_dunf), DW'(m_dunf));
      check("cmp_level", DW'(fifo_level), DW'(mq.size()));

      if ((dac_valid != '0) && (dac_ddata != '0)) cap.push_back(dac_ddata);
      if (dac_dunf) dunf_cnt++;
      if (dac_dunf && !dunf_prev) dunf_rise++;
      dunf_prev = dac_dunf;

      m_wr = axis_if.s_axis_valid && m_rdy;
      m_rd = (dac_valid != '0);
      if (enable == '0) begin
        mq.delete();
        m_ov = 1'b0; m_dunf = 1'b0; m_st = 0;
      end else begin
        m_dunf = 1'b0;
        if (m_st == 0) begin
          m_st = 1;
        end else if (m_st == 1) begin
          if (mq.size() >= START) m_st = 2;
        end else begin
          m_dunf = m_rd && !m_ov;
          if (!m_ov || m_rd) begin
            if (mq.size() != 0) begin
              m_od = mq.pop_front();
              m_ov = 1'b1;
            end else begin
              m_ov = 1'b0;
            end
          end
        end
        if (m_wr) mq.push_back(axis_if.s_axis_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic push(input int val);
    bit hs;
    int budget;
    hs = 1'b0;
    budget = 0;
    axis_if.s_axis_valid = 1'b1;
    axis_if.s_axis_data  = DW'(val);
    while (!hs && budget < 100) begin
      @(negedge clk);
      hs = axis_if.s_axis_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    axis_if.s_axis_valid = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=not_accepted expected=accepted word=%0d", val);
    end
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) push(first + i);
  endtask

  task automatic wait_cap(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (cap.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (cap.size() < n) begin
      failures++;
      $display("FAIL %s actual=%0d_words expected=%0d_words", name, cap.size(), n);
    end
  endtask

  // Captured stream must be exactly first, first+1, ... first+n-1.
  task automatic check_seq(input string name, input int first, input int n);
    int bad;
    bad = -1;
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && (i >= cap.size() || cap[i] !== DW'(first + i))) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      if (bad < cap.size())
        $display("FAIL %s index=%0d actual=%0h expected=%0h", name, bad, cap[bad], first + bad);
      else
        $display("FAIL %s index=%0d actual=missing expected=%0h", name, bad, first + bad);
    end
  endtask

  // Disable for one cycle (flush) and re-enable, leaving the FIFO in prefill.
  task automatic restart();
    enable = 2'b00;
    tick();
    check("dis_level", DW'(fifo_level), DW'(0));
    check("dis_ready", DW'(axis_if.s_axis_ready), DW'(0));
    enable = 2'b11;
    tick();
    check("reen_ready", DW'(axis_if.s_axis_ready), DW'(1));
    cap.delete();
    dunf_cnt  = 0;
    dunf_rise = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    enable    = 2'b00;
    dac_valid = 2'b00;
    axis_if.s_axis_valid = 1'b0;
    axis_if.s_axis_data  = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_ready", DW'(axis_if.s_axis_ready), DW'(0));
    check("rst_ddata", dac_ddata, DW'(0));
    check("rst_dunf",  DW'(dac_dunf), DW'(0));
    check("rst_level", DW'(fifo_level), DW'(0));
    enable = 2'b11;
    resetn = 1'b1;
    tick();
    check("rel_ready", DW'(axis_if.s_axis_ready), DW'(1));
    check("rel_level", DW'(fifo_level), DW'(0));

    // Prefill with the read strobe asserted throughout.
    dac_valid = 2'b11;
    push_range(1, 8);
    check("pf_level", DW'(fifo_level), DW'(8));
    check("pf_ddata", dac_ddata, DW'(0));
    check("pf_nodunf", DW'(dunf_cnt), DW'(0));
    wait_cap("pf_drain", 8, 40);
    dac_valid = 2'b00;
    check_seq("pf_order", 1, 8);
    repeat (3) tick();

    // Underflow: three isolated reads against an empty FIFO.
    dunf_cnt  = 0;
    dunf_rise = 0;
    for (int i = 0; i < 3; i++) begin
      dac_valid = 2'b11;
      tick();
      check("unf_ddata", dac_ddata, DW'(0));
      dac_valid = 2'b00;
      tick();
    end
    tick();
    check("unf_cycles", DW'(dunf_cnt), DW'(3));
    check("unf_pulses", DW'(dunf_rise), DW'(3));
    push(170);
    tick();
    check("unf_next_word", dac_ddata, DW'(170));
    check("unf_next_nodunf", DW'(dac_dunf), DW'(0));
    check("unf_cnt_same", DW'(dunf_cnt), DW'(3));
    dac_valid = 2'b11;
    tick();
    dac_valid = 2'b00;

    // Full: 16 stored plus one in the output register.
    restart();
    push_range(101, 17);
    check("full_level", DW'(fifo_level), DW'(16));
    check("full_ready", DW'(axis_if.s_axis_ready), DW'(0));
    axis_if.s_axis_valid = 1'b1;
    axis_if.s_axis_data  = DW'(118);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold", DW'(axis_if.s_axis_ready), DW'(0));
    end
    dac_valid = 2'b11;
    check("full_head", dac_ddata, DW'(101));
    tick();
    dac_valid = 2'b00;
    check("full_free_level", DW'(fifo_level), DW'(15));
    check("full_free_ready", DW'(axis_if.s_axis_ready), DW'(1));
    check("full_next_head", dac_ddata, DW'(102));
    tick();
    axis_if.s_axis_valid = 1'b0;
    check("full_refill_level", DW'(fifo_level), DW'(16));
    check("full_refill_ready", DW'(axis_if.s_axis_ready), DW'(0));
    dac_valid = 2'b11;
    wait_cap("full_drain", 18, 60);
    dac_valid = 2'b00;
    check_seq("full_order", 101, 18);

    // Wrap: 100 words, reading every cycle once prefill is done.
    restart();
    push_range(1001, 8);
    dac_valid = 2'b11;
    push_range(1009, 92);
    wait_cap("wrap_drain", 100, 60);
    dac_valid = 2'b00;
    check_seq("wrap_order", 1001, 100);
    check("wrap_count", DW'(cap.size()), DW'(100));

    // Disable mid-stream with five words stored.
    restart();
    push_range(2001, 5);
    check("mid_level", DW'(fifo_level), DW'(5));
    enable = 2'b00;
    tick();
    check("mid_dis_level", DW'(fifo_level), DW'(0));
    check("mid_dis_ready", DW'(axis_if.s_axis_ready), DW'(0));
    check("mid_dis_ddata", dac_ddata, DW'(0));
    enable = 2'b11;
    tick();
    check("mid_reen_ready", DW'(axis_if.s_axis_ready), DW'(1));
    check("mid_reen_level", DW'(fifo_level), DW'(0));
    cap.delete();
    dac_valid = 2'b11;
    push_range(3001, 7);
    repeat (3) tick();
    check("mid_prefill_level", DW'(fifo_level), DW'(7));
    check("mid_prefill_ddata", dac_ddata, DW'(0));
    check("mid_prefill_nocap", DW'(cap.size()), DW'(0));
    push(3008);
    wait_cap("mid_drain", 8, 40);
    dac_valid = 2'b00;
    check_seq("mid_order", 3001, 8);

    // Asynchronous reset while words are stored.
    restart();
    push_range(4001, 4);
    resetn = 1'b0;
    #1;
    check("areset_level", DW'(fifo_level), DW'(0));
    check("areset_ready", DW'(axis_if.s_axis_ready), DW'(0));
    check("areset_ddata", dac_ddata, DW'(0));
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("areset_rel_ready", DW'(axis_if.s_axis_ready), DW'(1));
    check("areset_rel_level", DW'(fifo_level), DW'(0));
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
